// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: instruction memory bus, redirect inputs and decode valid/ready handshake.
// The fetch unit is the master; the memory and decode side is the slave.
interface instruction_fetch_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] instruction_address;
    logic [DATA_WIDTH-1:0] instruction_data;
    logic                  fetch_enable;
    logic                  branch_valid;
    logic [ADDR_WIDTH-1:0] branch_target;
    logic                  fetch_valid;
    logic                  fetch_ready;
    logic [DATA_WIDTH-1:0] fetch_instruction;
    logic [ADDR_WIDTH-1:0] fetch_pc;
    modport master (
        output instruction_address, fetch_valid, fetch_instruction, fetch_pc,
        input  instruction_data, fetch_enable, branch_valid, branch_target, fetch_ready
    );
    modport slave (
        input  instruction_address, fetch_valid, fetch_instruction, fetch_pc,
        output instruction_data, fetch_enable, branch_valid, branch_target, fetch_ready
    );
endinterface

// File: rtl/instruction_fetch.sv
// instruction_fetch: owns the PC and prefetches {pc, word} pairs into a small FIFO for decode.
// A branch flushes the FIFO and redirects the PC; the head reads as zero whenever the FIFO is empty.
module instruction_fetch #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int RESET_PC   = 0,
    parameter int FIFO_DEPTH = 2
) (
    input logic clk,
    input logic rst_n,
    instruction_fetch_if.master bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(FIFO_DEPTH);
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] pc_buf [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] word_buf [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0] count;
    logic pop, push;
    assign pop = bus.fetch_valid & bus.fetch_ready;
    // A pop frees a slot in the same cycle, so a full FIFO still streams at one word per cycle.
    assign push = bus.fetch_enable & ~bus.branch_valid & ((count < FULL) | pop);
    assign bus.instruction_address = pc;
    assign bus.fetch_valid = count != '0;
    assign bus.fetch_instruction = bus.fetch_valid ? word_buf[rd_ptr] : '0;
    assign bus.fetch_pc = bus.fetch_valid ? pc_buf[rd_ptr] : '0;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            pc     <= ADDR_WIDTH'(RESET_PC);
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (bus.branch_valid) begin
            pc     <= bus.branch_target;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            pc     <= push ? pc + ADDR_WIDTH'(1) : pc;
            wr_ptr <= push ? wr_ptr + PW'(1) : wr_ptr;
            rd_ptr <= pop ? rd_ptr + PW'(1) : rd_ptr;
            count  <= (push & ~pop) ? count + (PW+1)'(1) : (pop & ~push) ? count - (PW+1)'(1) : count;
        end
    always_ff @(posedge clk)
        if (push) begin
            pc_buf[wr_ptr]   <= pc;
            word_buf[wr_ptr] <= bus.instruction_data;
        end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: vector table for reset/backpressure/branch/enable, scoreboard for wrap
// streaming, and an asynchronous mid-stream reset; memory model is mem[a] = a ^ 8'hA5.
module tb_instruction_fetch;
    typedef struct {
        logic       en, rdy, br;
        logic [7:0] tgt, addr;
        logic       vld;
        logic [7:0] fpc, word;
    } vec_t;
    typedef struct packed {
        logic [7:0] pc, word;
    } ent_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int errors = 0;
    int checks = 0;
    vec_t vecs [17];
    ent_t sb [$];
    ent_t e;
    int first_pop, last_pop;
    instruction_fetch_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus ();
    instruction_fetch #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .RESET_PC(0), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    assign bus.instruction_data = bus.instruction_address ^ 8'hA5;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h01, 1'b1, 8'h00, 8'hA5};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h02, 1'b1, 8'h00, 8'hA5};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h02, 1'b1, 8'h00, 8'hA5};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h02, 1'b1, 8'h00, 8'hA5};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 8'h00, 8'h02, 1'b1, 8'h00, 8'hA5};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 8'h00, 8'h03, 1'b1, 8'h01, 8'hA4};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 8'h00, 8'h04, 1'b1, 8'h02, 8'hA7};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 8'h40, 8'h05, 1'b1, 8'h03, 8'hA6};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 8'h00, 8'h40, 1'b0, 8'h00, 8'h00};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h41, 1'b1, 8'h40, 8'hE5};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h42, 1'b1, 8'h40, 8'hE5};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h42, 1'b1, 8'h41, 8'hE4};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h42, 1'b0, 8'h00, 8'h00};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h42, 1'b0, 8'h00, 8'h00};
        vecs[15] = '{1'b0, 1'b1, 1'b1, 8'hFE, 8'h42, 1'b0, 8'h00, 8'h00};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'hFE, 1'b0, 8'h00, 8'h00};
        bus.fetch_enable  = 1'b1;
        bus.fetch_ready   = 1'b0;
        bus.branch_valid  = 1'b0;
        bus.branch_target = 8'h00;
        step();
        step();
        check("reset.addr", 32'(bus.instruction_address), 32'h00);
        check("reset.valid", 32'(bus.fetch_valid), 32'h0);
        check("reset.instr", 32'(bus.fetch_instruction), 32'h00);
        check("reset.pc", 32'(bus.fetch_pc), 32'h00);
        rst_n = 1'b1;
        for (int i = 0; i < 17; i++) begin
            bus.fetch_enable  = vecs[i].en;
            bus.fetch_ready   = vecs[i].rdy;
            bus.branch_valid  = vecs[i].br;
            bus.branch_target = vecs[i].tgt;
            check($sformatf("v%0d.addr", i), 32'(bus.instruction_address), 32'(vecs[i].addr));
            check($sformatf("v%0d.valid", i), 32'(bus.fetch_valid), 32'(vecs[i].vld));
            check($sformatf("v%0d.pc", i), 32'(bus.fetch_pc), 32'(vecs[i].fpc));
            check($sformatf("v%0d.instr", i), 32'(bus.fetch_instruction), 32'(vecs[i].word));
            step();
        end
        bus.branch_valid = 1'b0;
        bus.fetch_enable = 1'b1;
        bus.fetch_ready  = 1'b1;
        sb.push_back('{8'hFE, 8'h5B});
        sb.push_back('{8'hFF, 8'h5A});
        sb.push_back('{8'h00, 8'hA5});
        sb.push_back('{8'h01, 8'hA4});
        first_pop = -1;
        last_pop  = -1;
        for (int c = 0; c < 20 && sb.size() != 0; c++) begin
            if (bus.fetch_valid && bus.fetch_ready) begin
                e = sb.pop_front();
                check("wrap.pc", 32'(bus.fetch_pc), 32'(e.pc));
                check("wrap.instr", 32'(bus.fetch_instruction), 32'(e.word));
                if (first_pop < 0) first_pop = c;
                last_pop = c;
            end
            step();
        end
        check("wrap.drained", 32'(sb.size()), 32'd0);
        check("wrap.no_bubble", 32'(last_pop - first_pop), 32'd3);
        bus.fetch_ready = 1'b0;
        step();
        step();
        step();
        check("full.valid", 32'(bus.fetch_valid), 32'h1);
        #3;
        rst_n = 1'b0;
        #1;
        check("async.valid", 32'(bus.fetch_valid), 32'h0);
        check("async.addr", 32'(bus.instruction_address), 32'h00);
        check("async.instr", 32'(bus.fetch_instruction), 32'h00);
        check("async.pc", 32'(bus.fetch_pc), 32'h00);
        step();
        rst_n = 1'b1;
        bus.fetch_ready = 1'b1;
        check("rel.valid0", 32'(bus.fetch_valid), 32'h0);
        step();
        check("rel.valid1", 32'(bus.fetch_valid), 32'h1);
        check("rel.head0", 32'({bus.fetch_pc, bus.fetch_instruction}), 32'h00A5);
        step();
        check("rel.head1", 32'({bus.fetch_pc, bus.fetch_instruction}), 32'h01A4);
        check("rel.addr", 32'(bus.instruction_address), 32'h02);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
